// File: rtl/mdu_result_fifo.sv
// In-order result buffer between the MDU and one CDB write port.
// Circular queue with a valid/ready interface on both sides; readiness depends only on occupancy.
module mdu_result_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_data_i,
  input  logic [ID_W-1:0]   res_reg_id_i,
  output logic              fifo_ready_o,
  output logic              cdb_valid_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [ID_W-1:0]   cdb_reg_id_o,
  input  logic              cdb_ready_i,
  output logic [PTR_W:0]    count_o
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             enq;
  logic             deq;

  // A full queue refuses input even when the head retires in the same cycle.
  assign fifo_ready_o = (count_q != CNT_W'(DEPTH));
  assign cdb_valid_o  = (count_q != '0);
  assign enq          = res_valid_i & fifo_ready_o;
  assign deq          = cdb_valid_o & cdb_ready_i;
  assign count_o      = count_q;

  assign cdb_data_o   = cdb_valid_o ? mem_q[head_q].data : '0;
  assign cdb_reg_id_o = cdb_valid_o ? mem_q[head_q].id   : '0;

  // Next-state pointers and occupancy; flush overrides any transfer.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + PTR_W'(1);
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; entries are only observable while counted.
  always_ff @(posedge clk) begin
    if (enq && !flush) begin
      mem_q[tail_q] <= '{data: res_data_i, id: res_reg_id_i};
    end
  end

endmodule

// File: tb/tb_mdu_result_fifo.sv
// Bench for mdu_result_fifo: directed scenarios plus a randomized run
// compared against a queue-based model of the buffer.
module tb_mdu_result_fifo;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 6;
  localparam int unsigned PTR_W  = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic [ID_W-1:0]   res_reg_id;
  logic              fifo_ready;
  logic              cdb_valid;
  logic [DATA_W-1:0] cdb_data;
  logic [ID_W-1:0]   cdb_reg_id;
  logic              cdb_ready;
  logic [PTR_W:0]    count;

  int errors = 0;
  int checks = 0;
  bit allow_drop = 1'b0;

  logic [DATA_W+ID_W-1:0] mq[$];

  mdu_result_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .res_valid_i  (res_valid),
    .res_data_i   (res_data),
    .res_reg_id_i (res_reg_id),
    .fifo_ready_o (fifo_ready),
    .cdb_valid_o  (cdb_valid),
    .cdb_data_o   (cdb_data),
    .cdb_reg_id_o (cdb_reg_id),
    .cdb_ready_i  (cdb_ready),
    .count_o      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The producer must never offer a result to a full queue in system use.
  always @(negedge clk) begin
    if (!rst && !allow_drop) begin
      assert (!(res_valid && !fifo_ready)) else begin
        errors++;
        $display("FAIL drop_guard: res_valid=1 while fifo_ready=0");
      end
    end
  end

  function automatic int exp_count();
    return mq.size();
  endfunction

  function automatic logic [ID_W-1:0] exp_id();
    logic [DATA_W+ID_W-1:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[ID_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] exp_data();
    logic [DATA_W+ID_W-1:0] e;
    if (mq.size() == 0) return '0;
    e = mq[0];
    return e[DATA_W+ID_W-1:ID_W];
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return 1ns after it.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [ID_W-1:0] id,
                      input logic rdy, input logic fl);
    bit e, dq;
    res_valid  = v;
    res_data   = d;
    res_reg_id = id;
    cdb_ready  = rdy;
    flush      = fl;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      e  = v && (mq.size() < DEPTH);
      dq = (mq.size() != 0) && rdy;
      if (dq) void'(mq.pop_front());
      if (e) mq.push_back({d, id});
    end
    #1;
    res_valid = 1'b0;
    flush     = 1'b0;
    cdb_ready = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; res_valid = 1'b0; res_data = '0; res_reg_id = '0; cdb_ready = 1'b0;
    #12;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (cdb_valid !== 1'b0 || fifo_ready !== 1'b1) begin errors++;
      $display("FAIL reset_flags: valid=%b ready=%b want 0/1", cdb_valid, fifo_ready); end
    @(negedge clk); rst = 1'b0;
    for (int i = 1; i <= 3; i++) step(1'b1, DATA_W'(32'h100 + i), ID_W'(i), 1'b0, 1'b0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL reset_prefill: got %0d want 3", count); end
    #3 rst = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || cdb_valid !== 1'b0 || fifo_ready !== 1'b1) begin errors++;
      $display("FAIL reset_async: count=%0d valid=%b ready=%b want 0/0/1", count, cdb_valid, fifo_ready); end
    checks++; if (cdb_data !== '0 || cdb_reg_id !== '0) begin errors++;
      $display("FAIL reset_outputs: data=%h id=%0d want 0/0", cdb_data, cdb_reg_id); end
    mq.delete();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [DATA_W-1:0] dv;
    for (int i = 1; i <= 4; i++) begin
      dv = DATA_W'(8'h11 * i);
      step(1'b1, dv, ID_W'(i), 1'b0, 1'b0);
    end
    checks++; if (fifo_ready !== 1'b0 || count !== 3'd4) begin errors++;
      $display("FAIL fill_full: ready=%b count=%0d want 0/4", fifo_ready, count); end
    for (int i = 1; i <= 4; i++) begin
      dv = DATA_W'(8'h11 * i);
      checks++; if (cdb_valid !== 1'b1 || cdb_reg_id !== ID_W'(i) || cdb_data !== dv) begin errors++;
        $display("FAIL drain_order: valid=%b id=%0d data=%h want 1/%0d/%h", cdb_valid, cdb_reg_id, cdb_data, i, dv); end
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (cdb_valid !== 1'b0 || count !== 3'd0) begin errors++;
      $display("FAIL drain_empty: valid=%b count=%0d want 0/0", cdb_valid, count); end
  endtask

  task automatic test_full_refusal();
    for (int i = 21; i <= 24; i++) step(1'b1, DATA_W'(i), ID_W'(i), 1'b0, 1'b0);
    allow_drop = 1'b1;
    step(1'b1, 32'h9999, ID_W'(9), 1'b1, 1'b0);
    allow_drop = 1'b0;
    checks++; if (count !== 3'd3 || cdb_reg_id !== ID_W'(22)) begin errors++;
      $display("FAIL full_refuse: count=%0d head=%0d want 3/22", count, cdb_reg_id); end
    for (int i = 22; i <= 24; i++) begin
      checks++; if (cdb_reg_id !== ID_W'(i)) begin errors++;
        $display("FAIL full_refuse_order: id=%0d want %0d", cdb_reg_id, i); end
      step(1'b0, '0, '0, 1'b1, 1'b0);
    end
    checks++; if (cdb_valid !== 1'b0) begin errors++;
      $display("FAIL full_refuse_leak: valid=%b id=%0d want empty", cdb_valid, cdb_reg_id); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 32'h55, ID_W'(5), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checks++; if (cdb_reg_id !== ID_W'(5 + k)) begin errors++;
        $display("FAIL b2b_head: id=%0d want %0d", cdb_reg_id, 5 + k); end
      step(1'b1, DATA_W'(32'h50 + k), ID_W'(6 + k), 1'b1, 1'b0);
      checks++; if (count !== 3'd1) begin errors++;
        $display("FAIL b2b_count: count=%0d want 1", count); end
    end
    checks++; if (cdb_reg_id !== ID_W'(11) || cdb_data !== 32'h55) begin errors++;
      $display("FAIL b2b_last: id=%0d data=%h want 11/55", cdb_reg_id, cdb_data); end
    drain();
  endtask

  task automatic test_flush();
    step(1'b1, 32'h1, ID_W'(1), 1'b0, 1'b0);
    step(1'b1, 32'h2, ID_W'(2), 1'b0, 1'b0);
    step(1'b1, 32'h7, ID_W'(7), 1'b1, 1'b1);
    checks++; if (count !== 3'd0 || cdb_valid !== 1'b0) begin errors++;
      $display("FAIL flush_clear: count=%0d valid=%b want 0/0", count, cdb_valid); end
    step(1'b1, 32'h8, ID_W'(8), 1'b0, 1'b0);
    checks++; if (count !== 3'd1 || cdb_reg_id !== ID_W'(8)) begin errors++;
      $display("FAIL flush_restart: count=%0d id=%0d want 1/8", count, cdb_reg_id); end
    drain();
  endtask

  task automatic test_hold();
    step(1'b1, 32'hDEADBEEF, ID_W'(3), 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0);
      checks++; if (cdb_valid !== 1'b1 || cdb_reg_id !== ID_W'(3) || cdb_data !== 32'hDEADBEEF) begin errors++;
        $display("FAIL hold_stable: valid=%b id=%0d data=%h want 1/3/deadbeef", cdb_valid, cdb_reg_id, cdb_data); end
    end
    step(1'b0, '0, '0, 1'b1, 1'b0);
    checks++; if (cdb_valid !== 1'b0 || count !== 3'd0) begin errors++;
      $display("FAIL hold_retire: valid=%b count=%0d want 0/0", cdb_valid, count); end
  endtask

  task automatic test_random();
    allow_drop = 1'b1;
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, ID_W'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 3));
      checks++; if (int'(count) != exp_count()) begin errors++;
        $display("FAIL rand_count cyc %0d: got %0d want %0d", n, count, exp_count()); end
      checks++; if (fifo_ready !== (exp_count() != DEPTH) || cdb_valid !== (exp_count() != 0)) begin errors++;
        $display("FAIL rand_flags cyc %0d: ready=%b valid=%b count_model=%0d", n, fifo_ready, cdb_valid, exp_count()); end
      checks++; if (cdb_reg_id !== exp_id() || cdb_data !== exp_data()) begin errors++;
        $display("FAIL rand_head cyc %0d: id=%0d data=%h want %0d/%h", n, cdb_reg_id, cdb_data, exp_id(), exp_data()); end
    end
    allow_drop = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_refusal();
    test_back_to_back();
    test_flush();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
